unit_hazard_forward: RTL

Parametrised successor to the two-source EX forwarding unit. It generates ALU operand-select codes from N forwarding sources with youngest-first priority, and never forwards register 0. It adds a sequential load-use hazard controller that stalls the front end for a configurable number of cycles and reports stall activity. It sits between the ID/EX pipeline register and the EX-stage operand muxes, and drives the PC/IF-ID freeze and the ID/EX bubble.

---
 rtl/unit_hazard_forward.sv | 120 ++++++++++++
 1 files changed

// File: rtl/unit_hazard_forward.sv
// EX-stage forwarding select for N_FWD sources plus a load-use stall controller.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module unit_hazard_forward #(
  parameter int BITS_REGS          = 5,
  parameter int BITS_CORTOCIRCUITO = 3,
  parameter int N_FWD              = 2,
  parameter int LOAD_STALL_CYCLES  = 1,
  parameter int BITS_CNT           = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [BITS_REGS-1:0]          i_IDEX_rs,
  input  logic [BITS_REGS-1:0]          i_IDEX_rt,
  input  logic [N_FWD-1:0]              i_fwd_write,
  input  logic [N_FWD*BITS_REGS-1:0]    i_fwd_rdrt,
  input  logic                          i_IDEX_mem_read,
  input  logic [BITS_REGS-1:0]          i_IDEX_rdrt,
  input  logic [BITS_REGS-1:0]          i_IFID_rs,
  input  logic [BITS_REGS-1:0]          i_IFID_rt,
  output logic [BITS_CORTOCIRCUITO-1:0] o_mux_A,
  output logic [BITS_CORTOCIRCUITO-1:0] o_mux_B,
  output logic                          o_stall,
  output logic                          o_flush_IDEX,
  output logic [BITS_CNT-1:0]           o_stall_count,
  output logic [BITS_CNT-1:0]           o_fwd_count
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t         state;
  logic [2:0]     rem;
  logic           hazard;
  logic           hit_a;
  logic           hit_b;
  logic [BITS_REGS-1:0] src_rd [N_FWD];

  always_comb begin
    for (int unsigned k = 0; k < N_FWD; k++) begin
      src_rd[k] = i_fwd_rdrt[k*BITS_REGS +: BITS_REGS];
    end
  end

  // Ascending scan with a hit flag so the youngest matching source wins.
  always_comb begin
    o_mux_A = '0;
    o_mux_B = '0;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    for (int unsigned k = 0; k < N_FWD; k++) begin
      if (!hit_a && i_fwd_write[k] && (src_rd[k] != '0) && (src_rd[k] == i_IDEX_rs)) begin
        o_mux_A = BITS_CORTOCIRCUITO'(k + 1);
        hit_a   = 1'b1;
      end
      if (!hit_b && i_fwd_write[k] && (src_rd[k] != '0) && (src_rd[k] == i_IDEX_rt)) begin
        o_mux_B = BITS_CORTOCIRCUITO'(k + 1);
        hit_b   = 1'b1;
      end
    end
  end

  assign hazard = i_IDEX_mem_read && (i_IDEX_rdrt != '0) &&
                  ((i_IDEX_rdrt == i_IFID_rs) || (i_IDEX_rdrt == i_IFID_rt));

  assign o_stall      = (state == STALL) || hazard;
  assign o_flush_IDEX = o_stall;

  // The detection cycle is the first stall cycle; STALL covers the remainder.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= IDLE;
      rem   <= '0;
    end else if (i_enable) begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_STALL_CYCLES > 1)) begin
            state <= STALL;
            rem   <= 3'(LOAD_STALL_CYCLES - 1);
          end
        end
        STALL: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rem   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [BITS_CNT-1:0] stall_cnt;
  logic [BITS_CNT-1:0] fwd_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (i_enable) begin
      if (o_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + BITS_CNT'(1);
      end
      if (((o_mux_A != '0) || (o_mux_B != '0)) && (fwd_cnt != '1)) begin
        fwd_cnt <= fwd_cnt + BITS_CNT'(1);
      end
    end
  end

  assign o_stall_count = stall_cnt;
  assign o_fwd_count   = fwd_cnt;
`else
  assign o_stall_count = '0;
  assign o_fwd_count   = '0;
`endif

endmodule
